alu_issue_arbiter: RTL
======================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single arithmetic_and_logic_unit between two requesters: req0 is the decode stream and req1 is the
//  branch/address unit. Round-robin grant; one instruction in flight at a time.
//  Pulses the ALU enable for exactly one cycle per instruction, so a read-modify-write op (ADD rX,rX) never
//  double-commits. Returns the updated ALU status byte, plus an error flag, to the requester that issued.
// PARAMETERS
//  INST_W   48  instruction width presented to ALU
//  STAT_W   8   ALU status width
//  CNT_W    16  width of completed-op performance counter
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous reset, ACTIVE-LOW (0 = reset), sampled on posedge clk
//  req0_valid   in   1       requester 0 has an instruction
//  req0_ready   out  1       requester 0 instruction accepted this cycle (valid&ready)
//  req0_inst    in   INST_W  requester 0 instruction
//  req1_valid   in   1       requester 1 has an instruction
//  req1_ready   out  1       requester 1 accepted
//  req1_inst    in   INST_W  requester 1 instruction
//  resp0_valid  out  1       response for requester 0 pending
//  resp0_ready  in   1       requester 0 takes response
//  resp1_valid  out  1       response for requester 1 pending
//  resp1_ready  in   1       requester 1 takes response
//  resp_status  out  STAT_W  ALU status captured after the op (shared by both responses)
//  resp_err     out  1       1 = illegal op or ALU did not signal done
//  alu_en       out  1       ALU enable
//  alu_inst     out  INST_W  instruction to ALU (registered)
//  alu_done     in   1       ALU done (combinational, same cycle as alu_en)
//  alu_status   in   STAT_W  ALU status register output
//  busy         out  1       state != IDLE
//  ops_done     out  CNT_W   count of completed non-error ops
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, last_grant=1, alu_en=0, alu_inst=0, resp*_valid=0, resp_status=0,
//   resp_err=0, ops_done=0. Reset mid-op aborts; no response is produced for the aborted op.
//  FSM states: IDLE, ISSUE, SETTLE, RESP.
//  IDLE: grant = only valid requester; if both valid, grant = !last_grant. reqN_ready=1 combinationally for the
//   granted requester only; ready is 0 in every other state. On accept: inst_q<=inst, owner<=grant,
//   last_grant<=grant.
//   If inst[2:0]!=3'b100 (not an ALU op): resp_err<=1, resp_status<=alu_status, go to RESP; ALU is not enabled.
//   Else go to ISSUE.
//  ISSUE: alu_en=1 for this single cycle, alu_inst=inst_q. Latch err_q = !alu_done. Next state is SETTLE.
//  SETTLE: alu_en=0. The ALU status reg has updated at the ISSUE edge. resp_status<=alu_status, resp_err<=err_q.
//   ops_done<=ops_done+1 if !err_q, wrapping modulo 2^CNT_W. Next state is RESP.
//  RESP: resp<owner>_valid=1, held stable with resp_status/resp_err until resp<owner>_ready. Leave to IDLE on the
//   handshake cycle. The other resp_valid stays 0.
//  Latency, accept to response valid: 3 cycles (accept edge -> ISSUE -> SETTLE -> RESP). Illegal op: 1 cycle.
//  Throughput: one op per 4 cycles minimum; no bypass from RESP to accept.
//  alu_en is never high in two consecutive cycles. alu_inst holds its last value when idle.
//  A requester whose valid drops before grant loses nothing; the arbiter never samples an unaccepted inst.
//  Simultaneous new request and response handshake in RESP: the request waits for IDLE.
// TESTING
//  1. Reset low 2 cycles, then req0 ADD (inst[7:0]=8'h84) -> alu_en exactly 1 cycle at T+1; resp0_valid at T+3;
//     ops_done=1.
//  2. req0 & req1 valid in the same cycle, continuously -> grants alternate 0,1,0,1. First grant is req0.
//     Never two consecutive grants to one side.
//  3. req1 inst[2:0]=3'b010 -> no alu_en pulse; resp1_valid next cycle with resp_err=1; ops_done unchanged.
//  4. resp0_ready held low 5 cycles -> resp0_valid, resp_status and resp_err stable. req1_ready=0 throughout.
//  5. SUB producing zero result -> resp_status[0]=1. Following nonzero ADD -> resp_status[0]=0.
//  6. rst low during SETTLE -> next cycle IDLE, no resp_valid, ops_done=0. ops_done preset 16'hFFFF + 1 op -> 0.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter_if
//   Requester-side bundle of the ALU issue arbiter: two instruction request
//   channels (valid/ready/inst) and two response channels (valid/ready) that
//   share one status byte and one error flag.
//
//   modport master : the requesters (drive requests, take responses)
//   modport slave  : the arbiter    (accepts requests, drives responses)
//
//   Parameters
//     INST_W  instruction width
//     STAT_W  ALU status width
// ---------------------------------------------------------------------------
interface alu_issue_arbiter_if #(
  parameter int INST_W = 48,
  parameter int STAT_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [INST_W-1:0] req0_inst;
  logic              req1_valid;
  logic              req1_ready;
  logic [INST_W-1:0] req1_inst;
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [STAT_W-1:0] resp_status;
  logic              resp_err;

  modport master (
    output req0_valid, req0_inst, req1_valid, req1_inst, resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_status, resp_err
  );

  modport slave (
    input  req0_valid, req0_inst, req1_valid, req1_inst, resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_status, resp_err
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
//   Shares one ALU between the decode stream (requester 0) and the
//   branch/address unit (requester 1). Round-robin grant, one instruction in
//   flight, a single-cycle ALU enable per instruction, and the post-op ALU
//   status plus an error flag returned to the requester that issued.
//
//   Ports
//     clk         clock, all state on posedge
//     rst         synchronous reset, active low
//     bus         requester handshakes (alu_issue_arbiter_if.slave)
//     alu_en      ALU enable, high for exactly one cycle per legal op
//     alu_inst    instruction to the ALU (registered, holds when idle)
//     alu_done    ALU done, combinational in the alu_en cycle
//     alu_status  ALU status register output
//     busy        arbiter not idle
//     ops_done    completed non-error ops, wraps
// ---------------------------------------------------------------------------
module alu_issue_arbiter #(
  parameter int INST_W = 48,
  parameter int STAT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_arbiter_if.slave  bus,
  output logic                alu_en,
  output logic [INST_W-1:0]   alu_inst,
  input  logic                alu_done,
  input  logic [STAT_W-1:0]   alu_status,
  output logic                busy,
  output logic [CNT_W-1:0]    ops_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Low three bits of an instruction the ALU can execute.
  localparam logic [2:0] ALU_OP = 3'b100;

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic              err_q;
  logic              grant;
  logic              accept;
  logic              resp_hs;
  logic [INST_W-1:0] grant_inst;

  // Round-robin pick: a lone requester wins outright; when both ask, the
  // side that did not win last time gets the slot.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what keeps a latch from being inferred.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
  end

  // Ready means "accepted this cycle", so nothing is offered while reset is
  // being sampled.
  assign accept         = rst && (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept &&  grant;
  assign grant_inst     = grant ? bus.req1_inst : bus.req0_inst;

  assign bus.resp0_valid = (state == S_RESP) && !owner;
  assign bus.resp1_valid = (state == S_RESP) &&  owner;
  assign resp_hs         = owner ? bus.resp1_ready : bus.resp0_ready;
  assign busy            = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      err_q           <= 1'b0;
      alu_en          <= 1'b0;
      alu_inst        <= '0;
      bus.resp_status <= '0;
      bus.resp_err    <= 1'b0;
      ops_done        <= '0;
    end else begin
      // alu_en is a one-cycle pulse: it is only ever set on the accept edge
      // and cleared on the very next one, so two consecutive highs cannot
      // happen and a read-modify-write op commits once.
      alu_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            if (grant_inst[2:0] != ALU_OP) begin
              // Not an ALU op: answer straight away with the current status.
              bus.resp_err    <= 1'b1;
              bus.resp_status <= alu_status;
              state           <= S_RESP;
            end else begin
              alu_inst <= grant_inst;
              alu_en   <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          err_q <= !alu_done;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          // The ALU status register took the result on the ISSUE edge.
          bus.resp_status <= alu_status;
          bus.resp_err    <= err_q;
          if (!err_q) ops_done <= ops_done + 1'b1;
          state <= S_RESP;
        end
        S_RESP: begin
          if (resp_hs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
